// File: rtl/simon_pkg.sv
// Shared Simon128/256 constants, FSM state type and rotation helpers used by
// both the key schedule and the encryption core.
package simon_pkg;

    localparam int SIMON128_256_ROUNDS = 72;
    localparam int SIMON_WORD_W        = 64;

    localparam logic [63:0] SIMON_C64 = 64'hFFFF_FFFF_FFFF_FFFC;

    // Leftmost character of the published z4 string is bit 61, i.e. z4[0].
    localparam logic [61:0] SIMON_Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_LOAD,
        KS_EXPAND,
        KS_DONE
    } key_exp_state_t;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] x, input int unsigned r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic z4_bit(input logic [5:0] idx);
        return SIMON_Z4[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// One Simon128/256 key-schedule step: k_{i+4} from k_i, k_{i+1}, k_{i+3}
// and the z4 sequence bit for round i.
module simon_key_round
    import simon_pkg::*;
(
    input  logic [63:0] w0_i,
    input  logic [63:0] w1_i,
    input  logic [63:0] w3_i,
    input  logic        z_i,
    output logic [63:0] k_o
);

    logic [63:0] t;

    assign t   = ror64(w3_i, 3) ^ w1_i;
    assign k_o = SIMON_C64 ^ {63'd0, z_i} ^ w0_i ^ t ^ ror64(t, 1);

endmodule

// File: rtl/simon128_256_key_expand.sv
// Simon128/256 key schedule: accepts a 256-bit master key and streams round
// keys k0..k71 into the round-key memory, one registered write per cycle.
module simon128_256_key_expand
    import simon_pkg::*;
#(
    parameter int NUM_ROUNDS = SIMON128_256_ROUNDS,
    parameter int KEY_WIDTH  = SIMON_WORD_W,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*KEY_WIDTH-1:0]  master_key_i,
    input  logic                    master_key_vld_i,
    output logic                    master_key_rdy_o,
    output logic                    key_wr_en_o,
    output logic [ADDR_WIDTH-1:0]   key_wr_addr_o,
    output logic [KEY_WIDTH-1:0]    key_wr_data_o,
    output logic                    key_mem_full_o,
    output logic                    busy_o
);

    localparam logic [6:0] LAST_IDX  = 7'(NUM_ROUNDS - 1);
    localparam logic [6:0] LOAD_LAST = 7'd3;

    key_exp_state_t              state_q, state_d;
    logic [3:0][KEY_WIDTH-1:0]   win_q, win_d;
    logic [6:0]                  cnt_q, cnt_d;
    logic [5:0]                  zidx_q, zidx_d;
    logic                        wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
    logic [KEY_WIDTH-1:0]        wr_data_q, wr_data_d;
    logic                        full_q, full_d;
    logic                        busy_q, busy_d;
    logic                        rdy_q, rdy_d;

    logic                        accept;
    logic                        step;
    logic [1:0]                  load_sel;
    logic [KEY_WIDTH-1:0]        new_key;

    assign accept   = master_key_vld_i & rdy_q;
    assign load_sel = cnt_q[1:0] + 2'd1;

    simon_key_round u_round (
        .w0_i (win_q[0]),
        .w1_i (win_q[1]),
        .w3_i (win_q[3]),
        .z_i  (z4_bit(zidx_q)),
        .k_o  (new_key)
    );

    // cnt_q is the index of the key currently on the write port; the edge
    // computes what appears there next cycle, so every output is a flop.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        zidx_d    = zidx_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        full_d    = full_q;
        busy_d    = busy_q;
        rdy_d     = rdy_q;
        step      = 1'b0;

        unique case (state_q)
            KS_IDLE, KS_DONE: begin
                rdy_d = 1'b1;
                if (accept) begin
                    state_d   = KS_LOAD;
                    win_d     = master_key_i;
                    cnt_d     = 7'd0;
                    zidx_d    = 6'd0;
                    wr_en_d   = 1'b1;
                    wr_data_d = master_key_i[KEY_WIDTH-1:0];
                    full_d    = 1'b0;
                    busy_d    = 1'b1;
                    rdy_d     = 1'b0;
                end
            end
            KS_LOAD: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LOAD_LAST) begin
                    state_d = KS_EXPAND;
                    step    = 1'b1;
                end else begin
                    wr_data_d = win_q[load_sel];
                end
            end
            KS_EXPAND: begin
                if (cnt_q == LAST_IDX) begin
                    state_d   = KS_DONE;
                    cnt_d     = 7'd0;
                    wr_en_d   = 1'b0;
                    wr_data_d = '0;
                    full_d    = 1'b1;
                    busy_d    = 1'b0;
                    rdy_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    step  = 1'b1;
                end
            end
            default: state_d = KS_IDLE;
        endcase

        if (step) begin
            wr_data_d = new_key;
            win_d     = {new_key, win_q[3:1]};
            zidx_d    = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
        end

        wr_addr_d = {{(ADDR_WIDTH-7){1'b0}}, cnt_d};
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q   <= KS_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            zidx_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            zidx_q    <= zidx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    assign master_key_rdy_o = rdy_q;
    assign key_wr_en_o      = wr_en_q;
    assign key_wr_addr_o    = wr_addr_q;
    assign key_wr_data_o    = wr_data_q;
    assign key_mem_full_o   = full_q;
    assign busy_o           = busy_q;

endmodule

// File: doc/simon128_256_key_expand.md
# simon128_256_key_expand

Simon128/256 key-schedule stage that sits directly upstream of the encryption core. It accepts a 256-bit master key over a valid/ready handshake, expands it into the 72 round keys k0..k71, and writes them one per cycle into the shared round-key memory. When all 72 keys are written it raises `key_mem_full`, which the encryption core consumes as its "keys ready" qualifier.

## Interface
- `NUM_ROUNDS`, 72: round keys produced; fixed for Simon128/256.
- `KEY_WIDTH`, 64: word size n.
- `ADDR_WIDTH`, 9: key memory address width.

- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `master_key`  in  256  master key; k0=[63:0], k1=[127:64], k2=[191:128], k3=[255:192].
- `master_key_vld`  in  1  master key valid.
- `master_key_rdy`  out  1  block can accept a key.
- `key_wr_en`  out  1  key memory write strobe.
- `key_wr_addr`  out  ADDR_WIDTH  write address; equals round index i.
- `key_wr_data`  out  KEY_WIDTH  round key k_i.
- `key_mem_full`  out  1  all NUM_ROUNDS keys are valid in memory.
- `busy`  out  1  load or expansion in progress.

## Operation
- Accept: `master_key_vld & master_key_rdy`. `master_key_rdy` = 1 in IDLE and DONE, and 0 otherwise.
- FSM states:
  - IDLE: wait for accept, then go to LOAD.
  - LOAD: 4 cycles, writes k0..k3 from the captured key.
  - EXPAND: 68 cycles, writes k4..k71.
  - DONE: `key_mem_full`=1; accept goes to LOAD.
- On accept, capture the 4 key words into a shift window W[0..3] = k_i..k_{i+3}. Clear the round counter. Drop `key_mem_full` on the next cycle.
- Expansion for i = 0..67:
  - k_{i+4} = C ^ z4[i mod 62] ^ k_i ^ T ^ ror(T,1), where T = ror(k_{i+3},3) ^ k_{i+1}.
  - C = 64'hFFFF_FFFF_FFFF_FFFC.
  - z4[j] is a single bit XORed into bit 0 of the result.
- z4 is the 62-bit string 11010001111001101011011000100000010111000011001010010011101111, with index 0 the leftmost character. Implement it as a 62-bit constant with a wrapping 6-bit index: 61 goes to 0.
- Each cycle in EXPAND: compute the new word, shift the window (W0<=W1, W1<=W2, W2<=W3, W3<=new), and increment the counter.
- The round counter is 7 bits and runs 0..71. Write address = counter zero-extended to ADDR_WIDTH.
- Rotations are mod 64. All XORs are 64-bit, and no carries are involved.
- `master_key_vld` while busy: ignored (rdy=0); the source holds it.
- Re-key from DONE: allowed. `key_mem_full` falls, and the encryption core must not start until it rises again.
- Reset mid-expansion: abort immediately and return to IDLE. Partially written memory contents are don't-care because `key_mem_full`=0.

## Timing
- Reset values: `master_key_rdy`=0 during rst, then 1 from the first cycle after rst falls (IDLE). `key_wr_en`=0, `key_wr_addr`=0, `key_wr_data`=0, `key_mem_full`=0, `busy`=0.
- All outputs are registered.
- Accept at cycle t gives:
  - writes of k0..k71 at cycles t+1..t+72, with `key_wr_en` high continuously for 72 cycles and addresses 0..71 in order;
  - `key_mem_full`=1 from t+73;
  - `busy`=1 for t+1..t+72.
- Total latency from accept to `key_mem_full` is 73 cycles.
- Exactly one write per cycle. There is no backpressure from memory, which is single-port write and always accepts.
- If rst and accept occur in the same cycle, rst wins.

## Structure
- Shared package `simon_pkg`: `SIMON128_256_ROUNDS`=72, `SIMON_C64`, `SIMON_Z4` (62-bit), state enum `key_exp_state_t`, and the `ror64` functions. The encryption core reuses the round count and rotation helpers from here.
- One natural sub-module: `simon_key_round`, combinational. Inputs are W0, W1, W3 and the z bit; output is k_{i+4}. It is isolated for unit test.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0; `master_key_rdy`=1 from the first cycle after rst falls.
- Published vector: master_key = 1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100 → addr0 = 0706050403020100, addr3 = 1f1e1d1c1b1a1918, and k4..k71 match the C reference model. Chained with the encryption core, plaintext 74206e69206d6f6f_6d69732061207369 → ciphertext 8d2b5579afc8a3a0_3bf72a87efe7b868.
- Latency and handshake:
  - accept at t → 72 consecutive writes with addresses 0..71 and `key_mem_full` at t+73;
  - `master_key_vld` held throughout → no second accept before DONE.
- z4 wrap: all-zero master key → k66..k71 use z4[0..5] and match the model.
- Re-key from DONE: second key accepted → `key_mem_full` drops the next cycle, the full 72 writes repeat, and the new key set is correct.
- Reset mid-operation: rst at write 40 → `key_wr_en`=0 and `key_mem_full`=0 the next cycle, IDLE; a following key expands correctly.
